// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 write-back path.
package msrv32_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/msrv32_wb_fifo.sv
// In-order buffer for ALU results that lost the register-file write port.
// Exposes per-slot valid/rd so the parent can detect pending writes to a source.
module msrv32_wb_fifo
  import msrv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_push,
  input  wb_entry_t                        i_wdata,
  input  logic                             i_pop,
  output wb_entry_t                        o_head,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [DEPTH-1:0]                 o_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_rd
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);

  wb_entry_t        r_mem [DEPTH];
  ptr_t             r_wptr;
  ptr_t             r_rptr;
  logic [CntW-1:0]  r_count;
  logic [DEPTH-1:0] r_valid;

  logic w_do_push;
  logic w_do_pop;

  function automatic ptr_t f_inc(ptr_t p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr];
  assign o_valid   = r_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_rd[i] = r_mem[i].rd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= f_inc(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      // Clear before set: a full push+pop reuses the slot being popped.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_do_pop && (r_rptr == ptr_t'(i))) r_valid[i] <= 1'b0;
        if (w_do_push && (r_wptr == ptr_t'(i))) r_valid[i] <= 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_wb_unit.sv
// Write-back arbiter: load response > buffered ALU result > direct ALU result.
// Define MSRV32_WB_SCOREBOARD_EN to enable the pending-write scoreboard / busy outputs.
module msrv32_wb_unit
  import msrv32_pkg::*;
#(
  parameter int unsigned ALU_BUF_DEPTH = 2
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic                  alu_valid_in,
  input  logic [REG_ADDR_W-1:0] alu_rd_in,
  input  logic [XLEN-1:0]       alu_data_in,
  output logic                  alu_ready_out,
  input  logic                  ld_issue_in,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd_in,
  input  logic                  ld_valid_in,
  input  logic [REG_ADDR_W-1:0] ld_rd_in,
  input  logic [XLEN-1:0]       ld_data_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  output logic                  rs_1_busy_out,
  output logic                  rs_2_busy_out,
  output logic                  wr_en_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [XLEN-1:0]       rd_out
);

  logic                                     r_wr_en;
  wb_entry_t                                r_wr;
  logic                                     w_wr_en_d;
  wb_entry_t                                w_wr_d;
  logic                                     w_ld_win;
  logic                                     w_alu_acc;
  logic                                     w_alu_direct;
  logic                                     w_push;
  logic                                     w_pop;
  logic                                     w_full;
  logic                                     w_empty;
  wb_entry_t                                w_head;
  wb_entry_t                                w_alu_entry;
  logic [ALU_BUF_DEPTH-1:0]                 w_fifo_valid;
  logic [ALU_BUF_DEPTH-1:0][REG_ADDR_W-1:0] w_fifo_rd;

  // A load to x0 never claims the port, so it does not stall the ALU path.
  assign w_ld_win     = ld_valid_in && (ld_rd_in != '0);
  assign w_pop        = !w_empty && !w_ld_win;
  assign alu_ready_out = ms_riscv32_mp_rst_in || !w_full || w_pop;
  assign w_alu_acc    = alu_valid_in && alu_ready_out && (alu_rd_in != '0);
  assign w_alu_direct = w_alu_acc && w_empty && !w_ld_win;
  assign w_push       = w_alu_acc && !w_alu_direct;
  assign w_alu_entry  = '{rd: alu_rd_in, data: alu_data_in};

  msrv32_wb_fifo #(
    .DEPTH (ALU_BUF_DEPTH)
  ) u_fifo (
    .i_clk   (ms_riscv32_mp_clk_in),
    .i_rst   (ms_riscv32_mp_rst_in),
    .i_push  (w_push),
    .i_wdata (w_alu_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_valid (w_fifo_valid),
    .o_rd    (w_fifo_rd)
  );

  always_comb begin
    w_wr_en_d = 1'b0;
    w_wr_d    = r_wr;
    if (w_ld_win) begin
      w_wr_en_d = 1'b1;
      w_wr_d    = '{rd: ld_rd_in, data: ld_data_in};
    end else if (w_pop) begin
      w_wr_en_d = 1'b1;
      w_wr_d    = w_head;
    end else if (w_alu_direct) begin
      w_wr_en_d = 1'b1;
      w_wr_d    = w_alu_entry;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_wr_en <= 1'b0;
      r_wr    <= '0;
    end else begin
      r_wr_en <= w_wr_en_d;
      r_wr    <= w_wr_d;
    end
  end

  assign wr_en_out   = r_wr_en;
  assign rd_addr_out = r_wr.rd;
  assign rd_out      = r_wr.data;

`ifdef MSRV32_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_d;
  logic                w_rs1_fifo;
  logic                w_rs2_fifo;

  // The clear lands on the same edge that registers the write, so the value on
  // the write port is never reported busy unless a newer load re-set the bit.
  always_comb begin
    w_pending_d = r_pending;
    if (w_ld_win) w_pending_d[ld_rd_in] = 1'b0;
    if (ld_issue_in && (ld_issue_rd_in != '0)) w_pending_d[ld_issue_rd_in] = 1'b1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  always_comb begin
    w_rs1_fifo = 1'b0;
    w_rs2_fifo = 1'b0;
    for (int i = 0; i < ALU_BUF_DEPTH; i++) begin
      if (w_fifo_valid[i] && (w_fifo_rd[i] == rs_1_addr_in)) w_rs1_fifo = 1'b1;
      if (w_fifo_valid[i] && (w_fifo_rd[i] == rs_2_addr_in)) w_rs2_fifo = 1'b1;
    end
  end

  assign rs_1_busy_out = !ms_riscv32_mp_rst_in && (rs_1_addr_in != '0) &&
                         (r_pending[rs_1_addr_in] || w_rs1_fifo);
  assign rs_2_busy_out = !ms_riscv32_mp_rst_in && (rs_2_addr_in != '0) &&
                         (r_pending[rs_2_addr_in] || w_rs2_fifo);
`else
  logic w_unused_sb;
  assign w_unused_sb   = ^{ld_issue_in, ld_issue_rd_in, rs_1_addr_in, rs_2_addr_in,
                           w_fifo_valid, w_fifo_rd};
  assign rs_1_busy_out = 1'b0;
  assign rs_2_busy_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_wb_unit.sv
// Self-checking bench for msrv32_wb_unit: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_msrv32_wb_unit;

  localparam int unsigned DEPTH = 2;
`ifdef MSRV32_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        busy1;
  logic        busy2;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_wb_unit #(
    .ALU_BUF_DEPTH (DEPTH)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .alu_valid_in         (alu_valid),
    .alu_rd_in            (alu_rd),
    .alu_data_in          (alu_data),
    .alu_ready_out        (alu_ready),
    .ld_issue_in          (ld_issue),
    .ld_issue_rd_in       (ld_issue_rd),
    .ld_valid_in          (ld_valid),
    .ld_rd_in             (ld_rd),
    .ld_data_in           (ld_data),
    .rs_1_addr_in         (rs1),
    .rs_2_addr_in         (rs2),
    .rs_1_busy_out        (busy1),
    .rs_2_busy_out        (busy2),
    .wr_en_out            (wr_en),
    .rd_addr_out          (rd_addr),
    .rd_out               (rd_data)
  );

  // Reference model: queue of buffered ALU results, pending-load flags, expected write.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          pend[32];
  logic        m_wr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit ldw;
    if (rst) return 1'b1;
    ldw = ld_valid && (ld_rd != 0);
    return (q.size() < DEPTH) || (q.size() > 0 && !ldw);
  endfunction

  function automatic bit model_busy(input logic [4:0] rs);
    if (rst || !SB || rs == 0) return 1'b0;
    if (pend[rs]) return 1'b1;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_wr   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic model_clock();
    bit   ldw;
    bit   acc;
    ent_t e;
    if (rst) begin
      model_reset();
      last_acc = 1'b0;
      return;
    end
    ldw      = ld_valid && (ld_rd != 0);
    acc      = alu_valid && model_ready();
    last_acc = acc;
    m_wr     = 1'b0;
    if (ldw) begin
      m_wr = 1'b1; m_rd = ld_rd; m_data = ld_data;
      pend[ld_rd] = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_wr = 1'b1; m_rd = e.rd; m_data = e.data;
    end
    if (acc && alu_rd != 0) begin
      if (!m_wr) begin
        m_wr = 1'b1; m_rd = alu_rd; m_data = alu_data;
      end else begin
        e.rd = alu_rd; e.data = alu_data;
        q.push_back(e);
      end
    end
    if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1'b1;
  endtask

  // One clock: check all outputs at the falling edge, advance the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("alu_ready", alu_ready, model_ready());
    chk("rs1_busy", busy1, model_busy(rs1));
    chk("rs2_busy", busy2, model_busy(rs2));
    chk("wr_en", wr_en, m_wr);
    if (m_wr) begin
      chk("rd_addr", rd_addr, m_rd);
      chk("rd_out", rd_data, m_data);
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
  endtask

  initial begin
    int k;
    #1 rst = 1'b1;
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_rd_out", rd_data, 0);
    chk("reset_ready", alu_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Lone ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk("req028_wr_en", wr_en, 1);
    chk("req028_rd", rd_addr, 5);
    chk("req028_data", rd_data, 32'hDEADBEEF);
    tick();

    // Load and ALU collide: load first, ALU next cycle
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    tick();
    idle_inputs();
    chk("req029_c1_rd", rd_addr, 3);
    chk("req029_c1_data", rd_data, 32'h11);
    tick();
    chk("req029_c2_wr_en", wr_en, 1);
    chk("req029_c2_rd", rd_addr, 4);
    chk("req029_c2_data", rd_data, 32'h22);
    tick();

    // Three back-to-back loads against a steady ALU stream; source holds until accepted
    k = 0;
    for (int c = 0; c < 8; c++) begin
      ld_valid  = (c < 3); ld_rd = 5'(10 + c); ld_data = 32'h100 + c;
      alu_valid = (k < 4); alu_rd = 5'(20 + k); alu_data = 32'hA0 + k;
      if (c == 2) begin
        #1;
        chk("req030_ready_full", alu_ready, 0);
      end
      tick();
      if (last_acc) k++;
    end
    idle_inputs();
    chk("req030_all_accepted", k, 4);
    tick();

    // ALU result to x0 is swallowed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    chk("req032_no_wr", wr_en, 0);
    tick();

    // Scoreboard: issue, hold busy, commit, then set+clear in the same cycle
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    idle_inputs();
    rs1 = 5'd7;
    #1;
    chk("req031_busy_set", busy1, SB);
    tick();
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    tick();
    idle_inputs();
    chk("req031_busy_clear", busy1, 0);
    chk("req031_commit_rd", rd_addr, 7);
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
    tick();
    idle_inputs();
    chk("req031_set_wins", busy1, SB);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h79;
    tick();
    idle_inputs();
    rs1 = 5'd0;
    tick();

    // Fill the buffer, then reset in the middle of the burst
    for (int c = 0; c < 2; c++) begin
      ld_valid  = 1'b1; ld_rd = 5'(12 + c); ld_data = 32'h200 + c;
      alu_valid = 1'b1; alu_rd = 5'(24 + c); alu_data = 32'hB0 + c;
      tick();
    end
    chk("req033_buffered", q.size(), 2);
    ld_valid = 1'b1; ld_rd = 5'd14; rs1 = 5'd24; rs2 = 5'd25;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("req033_wr_en", wr_en, 0);
    chk("req033_rd", rd_addr, 0);
    chk("req033_data", rd_data, 0);
    chk("req033_ready", alu_ready, 1);
    chk("req033_busy1", busy1, 0);
    chk("req033_busy2", busy2, 0);
    tick();
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      ld_valid    = ($urandom_range(0, 9) < 3);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 9) < 2);
      ld_issue_rd = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_unit.md
MSRV32_WB_UNIT -- requirements
Module: msrv32_wb_unit

Interface
REQ-001 SHALL have parameter ALU_BUF_DEPTH, default 2, setting the number of ALU results that can be held while a load write wins the port.
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: asynchronous reset, active-high.
REQ-004 SHALL have ports alu_valid_in (in, 1), alu_rd_in (in, 5) and alu_data_in (in, 32): the single-cycle ALU result.
REQ-005 SHALL have port alu_ready_out, output, 1 bit: high when the ALU result is accepted this cycle.
REQ-006 SHALL have ports ld_issue_in (in, 1) and ld_issue_rd_in (in, 5): a load has been issued to memory for rd.
REQ-007 SHALL have ports ld_valid_in (in, 1), ld_rd_in (in, 5) and ld_data_in (in, 32): the load response; always accepted.
REQ-008 SHALL have ports rs_1_addr_in and rs_2_addr_in (in, 5): decode-stage source addresses.
REQ-009 SHALL have ports rs_1_busy_out and rs_2_busy_out (out, 1): the source has a write that is not yet committed.
REQ-010 SHALL have ports wr_en_out (out, 1), rd_addr_out (out, 5) and rd_out (out, 32): the register-file write port.

Function
REQ-011 SHALL register wr_en_out, rd_addr_out and rd_out, so a write appears one cycle after the winning input.
REQ-012 SHALL resolve write-port priority each cycle as: load response first, then the oldest buffered ALU entry, then the direct alu_valid_in.
REQ-013 SHALL push an accepted ALU result into the in-order ALU FIFO whenever it does not win the port; the FIFO pointers wrap modulo ALU_BUF_DEPTH.
REQ-014 SHALL drive alu_ready_out = !fifo_full || (fifo pop this cycle && no load); acceptance = alu_valid_in && alu_ready_out.
REQ-015 SHALL drop any result with rd = 0 (load or ALU): no write, no FIFO entry, and ALU acceptance still counted.
REQ-016 SHALL, when FIFO push and pop coincide, hold the occupancy unchanged and keep the order intact.
REQ-017 SHALL keep a 32-bit pending-load scoreboard: set bit rd on ld_issue_in when rd != 0, and clear it when that load response is written out.
REQ-018 SHALL let the set win when a set and a clear of the same rd happen in the same cycle.
REQ-019 SHALL assert rs_N_busy_out when pending[rs_N] is set or any valid FIFO entry targets rs_N; it SHALL be 0 for rs_N = 0.
REQ-020 SHALL NOT flag a value being written this cycle (wr_en_out with matching rd_addr_out) as busy, because the register file forwards it.
REQ-021 SHALL pulse wr_en_out for exactly one cycle per write; there is no back-pressure from the register file.

Reset
REQ-022 SHALL, on asynchronous assertion of reset, immediately clear wr_en_out, rd_addr_out, rd_out, the FIFO pointers and occupancy, and all scoreboard bits.
REQ-023 SHALL drive alu_ready_out = 1 and busy outputs = 0 while reset is held; results in flight at reset are discarded.

Configuration
REQ-024 SHALL, with MSRV32_WB_SCOREBOARD_EN defined, implement REQ-017..REQ-020.
REQ-025 SHALL, with MSRV32_WB_SCOREBOARD_EN undefined, omit the scoreboard, tie both busy outputs to 0 and ignore the ld_issue ports; the write path is unchanged.

Structure
REQ-026 SHALL place the constants REG_ADDR_W = 5, XLEN = 32 and NUM_REGS = 32 in shared package msrv32_pkg.
REQ-027 SHALL implement the ALU buffer as sub-module msrv32_wb_fifo (parameterised depth, push/pop/full/empty, entry read for busy compare).

Verification
REQ-028 SHALL cover: ALU rd=5 data=0xDEADBEEF with no load -> next cycle wr_en=1, rd_addr=5, rd_out=0xDEADBEEF.
REQ-029 SHALL cover: same-cycle load rd=3 data=0x11 and ALU rd=4 data=0x22 -> cycle+1 writes x3=0x11, cycle+2 writes x4=0x22.
REQ-030 SHALL cover: loads on 3 consecutive cycles with ALU valid every cycle -> two ALU results buffered, alu_ready_out=0 on the third cycle, no result lost, order preserved.
REQ-031 SHALL cover: ld_issue rd=7, then rs_1_addr=7 -> busy=1 until the response write commits, then 0; a set and clear of rd=7 in the same cycle keeps busy=1.
REQ-032 SHALL cover: ALU rd=0 data=0xFFFFFFFF -> no wr_en pulse, FIFO untouched.
REQ-033 SHALL cover: reset asserted mid-burst with the FIFO holding 2 entries -> outputs 0 at once, and after release no stale writes appear.
